// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch unit: FSM states, fetch step and
// queue entry layout.
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int unsigned INSTR_STEP = 4;

  // Entries are sized for the widest supported XLEN; narrower builds
  // zero-extend on push and truncate on pop.
  localparam int unsigned XLEN_MAX = 64;

  typedef struct packed {
    logic [XLEN_MAX-1:0] instr;
    logic [XLEN_MAX-1:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/prefetch_if.sv
// Bus bundle of the prefetch unit: icache request/response, redirect input and
// decode-side output handshake.
interface prefetch_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_instr;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_step;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_instr,
    input  redirect_valid,
    input  redirect_addr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_step
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_instr,
    output redirect_valid,
    output redirect_addr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_step
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: issues in-order icache fetches under a credit limit,
// queues responses with their PCs and squashes stale responses after a redirect.
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        rst,
  prefetch_if.master bus
);

  localparam int unsigned     CW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic            active, credit_ok, req_valid, req_fire;
  logic [XLEN-1:0] req_addr;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]   fifo_count;
  fifo_entry_t     push_entry, head_entry;
  logic [XLEN-1:0] tag_head;
  logic            tag_full, tag_empty;
  logic [CW-1:0]   tag_count;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic            unused_status;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
  assign req_valid = active & ~bus.redirect_valid & credit_ok;
  assign req_fire  = req_valid & bus.imem_req_ready;
  assign req_addr  = {pc_q[XLEN-1:2], 2'b00};

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;

  // A response is squashed while stale ones remain or when it meets a redirect.
  assign fifo_push = bus.imem_rsp_valid & ~bus.redirect_valid & (discard_q == '0);
  assign fifo_pop  = out_valid & bus.out_ready;

  assign push_entry.instr = XLEN_MAX'(bus.imem_rsp_instr);
  assign push_entry.pc    = XLEN_MAX'(tag_head);

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .flush (bus.redirect_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Addresses of outstanding requests, retired one per response (kept or not).
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .wdata (req_addr),
    .pop   (bus.imem_rsp_valid),
    .rdata (tag_head),
    .flush (1'b0),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign unused_status = ^{fifo_full, tag_full, tag_empty, tag_count, head_entry};

  assign out_valid       = ~fifo_empty;
  assign out_pc          = fifo_empty ? '0 : XLEN'(head_entry.pc);
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = out_pc;
  assign bus.out_instr   = fifo_empty ? '0 : XLEN'(head_entry.instr);
  assign bus.out_pc_step = out_pc + STEP;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);

    if (bus.redirect_valid) begin
      pc_d      = {bus.redirect_addr[XLEN-1:2], 2'b00};
      discard_d = inflight_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + STEP;
      if (bus.imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end

    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (bus.redirect_valid && (discard_d != '0)) state_d = DRAIN;
      DRAIN:   if (discard_d == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 The block SHALL have a parameter XLEN, default 32, giving the address and instruction width.
REQ-002 The block SHALL have a parameter DEPTH, default 4, giving the instruction queue depth; it is a power of two and at least 2.
REQ-003 The block SHALL have a parameter RESET_PC, default 0, giving the first fetch address.
REQ-004 The block SHALL have these ports: clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have these ports: rst  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have these ports: imem_req_valid out 1; imem_req_ready in 1; imem_req_addr out XLEN  fetch request to the instruction cache.
REQ-007 The block SHALL have these ports: imem_rsp_valid in 1; imem_rsp_instr in XLEN  in-order cache response; it cannot be back-pressured.
REQ-008 The block SHALL have these ports: redirect_valid in 1; redirect_addr in XLEN  jump or branch target from the execute stage.
REQ-009 The block SHALL have these ports: out_valid out 1; out_ready in 1; out_instr out XLEN; out_pc out XLEN; out_pc_step out XLEN  instruction to decode.

Function
REQ-010 The block SHALL hold a fetch PC register, a DEPTH-entry FIFO of {instr, pc}, an in-flight counter and a discard counter, each counter 0..DEPTH.
REQ-011 The block SHALL assert imem_req_valid when all three hold: state is RUN or DRAIN, redirect_valid is 0, and (FIFO count + in-flight) < DEPTH.
REQ-012 imem_req_addr SHALL equal the fetch PC with bits [1:0] forced to 0.
REQ-013 On a request handshake (imem_req_valid & imem_req_ready), the fetch PC SHALL become PC+4 modulo 2^XLEN, and in-flight SHALL increment.
REQ-014 On imem_rsp_valid, in-flight SHALL decrement. If discard > 0, the response SHALL be dropped and discard decremented; otherwise {imem_rsp_instr, address of the oldest in-flight request} SHALL be pushed to the FIFO.
REQ-015 The block SHALL track the addresses of in-flight requests in a DEPTH-entry tag queue so that out_pc matches the request order exactly.
REQ-016 out_valid SHALL equal FIFO not-empty; out_instr and out_pc SHALL come from the FIFO head; out_pc_step SHALL equal out_pc+4 modulo 2^XLEN.
REQ-017 out_valid, out_instr and out_pc SHALL be registered outputs with no combinational path from imem_rsp_*.
REQ-018 A pop SHALL occur on out_valid & out_ready, and a push and a pop in the same cycle SHALL be permitted, including when the FIFO is full.
REQ-019 On redirect_valid, in that same edge: the FIFO SHALL be flushed (any pop that cycle completes first); the fetch PC SHALL load redirect_addr with [1:0]=0; discard SHALL load in-flight minus any response arriving that cycle; a response arriving that cycle SHALL be dropped.
REQ-020 The FSM SHALL have state IDLE, which moves to RUN on the first clock after reset release and issues no requests.
REQ-021 The FSM SHALL have state RUN, which moves to DRAIN on redirect when the loaded discard value is > 0.
REQ-022 The FSM SHALL have state DRAIN, which moves to RUN when discard reaches 0; requests continue to be issued in DRAIN.
REQ-023 A redirect while in DRAIN SHALL reload discard as in REQ-019, and the state SHALL stay DRAIN unless the loaded value is 0.
REQ-024 The block SHALL never overflow the FIFO: the credit rule in REQ-011 guarantees space for every response that is not discarded.

Reset
REQ-025 While rst=0 the block SHALL hold: state=IDLE, fetch PC=RESET_PC, FIFO empty, in-flight=0, discard=0, imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0, out_pc_step=4.
REQ-026 A reset asserted mid-operation SHALL abandon all in-flight requests; the cache is reset by the same rst.

Structure
REQ-027 A shared package prefetch_pkg SHALL hold the FSM state enum {IDLE, RUN, DRAIN}, the constant INSTR_STEP=4, and the FIFO entry struct {instr, pc}.
REQ-028 One sub-module, sync_fifo (parameters WIDTH and DEPTH; ports push, pop, flush, full, empty, count), SHALL be instantiated twice: once for the instruction FIFO and once for the tag queue.

Verification
REQ-029 Reset release, RESET_PC=0x100, cache always ready with 1-cycle latency, out_ready=1 -> out_pc sequence 0x100, 0x104, 0x108, one instruction per cycle after fill.
REQ-030 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, FIFO full, imem_req_valid=0; release -> 4 pops in order, then fetching resumes.
REQ-031 Redirect to 0x2002 with 2 requests in flight -> both responses dropped, next out_pc=0x2000, and no stale instruction appears.
REQ-032 Redirect in the same cycle as a response and a pop -> the popped instruction is delivered once, the response is dropped, and the FIFO is empty the next cycle.
REQ-033 Fetch PC=0xFFFF_FFFC (XLEN=32) -> next request address 0x0000_0000, and out_pc_step=0x0000_0000.
REQ-034 rst pulsed low with 3 in flight and FIFO half full -> all outputs return to their reset values immediately, and the first request after release is at RESET_PC.
